// File: rtl/sc_scratchpad.sv
// rtl/sc_scratchpad.sv - multi-lane scratchpad with 1-cycle reads, N write ports and post-reset clear
//
// Ports:
//   clk, n_rst        clock, asynchronous active-low reset
//   sc_x_queue[N]     per-lane x read byte address
//   sc_w_queue[N]     per-lane w read byte address
//   sc_valid_queue[N] per-lane read enable (both x and w ports of the lane)
//   sc_valid_write[N] per-lane write enable
//   sc_write_queue[N] per-lane write byte address
//   sc_write_data[N]  per-lane write data
//   sc_x_data[N]      per-lane registered x read data
//   sc_w_data[N]      per-lane registered w read data
//   init_busy         high while memory is being cleared after reset
//   addr_err          sticky out-of-range access flag
//   err_clr           synchronous clear of addr_err (a new error wins)
module sc_scratchpad #(
    parameter int N     = 64,
    parameter int DEPTH = 4096
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [N-1:0][31:0]  sc_x_queue,
    input  logic [N-1:0][31:0]  sc_w_queue,
    input  logic [N-1:0]        sc_valid_queue,
    input  logic [N-1:0]        sc_valid_write,
    input  logic [N-1:0][31:0]  sc_write_queue,
    input  logic [N-1:0][31:0]  sc_write_data,
    output logic [N-1:0][31:0]  sc_x_data,
    output logic [N-1:0][31:0]  sc_w_data,
    output logic                init_busy,
    output logic                addr_err,
    input  logic                err_clr
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] clr_cnt;
    logic [31:0]   mem [DEPTH];
    logic          new_err;

    // Byte-offset bits are ignored by design; fold them into a sink so the
    // partially used address buses are fully consumed.
    logic unused_lsbs;
    assign unused_lsbs = ^{sc_x_queue, sc_w_queue, sc_write_queue};

    function automatic logic in_range(input logic [31:0] a);
        return a[31:AW+2] == '0;
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return a[AW+1:2];
    endfunction

    // State register and clear counter. The counter saturates at DEPTH-1
    // so READY can never fall back into CLEAR.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR && clr_cnt != '1)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_cnt == '1)
            state_nxt = READY;
    end

    always_comb begin
        init_busy = (state == CLEAR);
    end

    // Storage. Lanes are visited in ascending order, so the last non-blocking
    // assignment to an index (highest lane) is the one that sticks.
    always_ff @(posedge clk) begin
        if (init_busy) begin
            mem[clr_cnt] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sc_valid_write[i] && in_range(sc_write_queue[i]))
                    mem[word_idx(sc_write_queue[i])] <= sc_write_data[i];
            end
        end
    end

    // Registered reads sample mem before this edge's writes land, which
    // gives read-before-write for same-cycle accesses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sc_x_data <= '0;
            sc_w_data <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sc_valid_queue[i]) begin
                    sc_x_data[i] <= (!init_busy && in_range(sc_x_queue[i]))
                                    ? mem[word_idx(sc_x_queue[i])] : '0;
                    sc_w_data[i] <= (!init_busy && in_range(sc_w_queue[i]))
                                    ? mem[word_idx(sc_w_queue[i])] : '0;
                end
            end
        end
    end

    always_comb begin
        new_err = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sc_valid_queue[i] &&
                (!in_range(sc_x_queue[i]) || !in_range(sc_w_queue[i])))
                new_err = 1'b1;
            if (sc_valid_write[i] && !in_range(sc_write_queue[i]))
                new_err = 1'b1;
        end
    end

    // The flag is frozen during the clear sequence.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_err <= 1'b0;
        end else if (!init_busy) begin
            if (new_err)
                addr_err <= 1'b1;
            else if (err_clr)
                addr_err <= 1'b0;
        end
    end

endmodule
